// File: rtl/fifo_rr_arbiter_if.sv
// Bundle of producer beat streams, FIFO write port and grant status for fifo_rr_arbiter.
// master is the arbiter side; slave is the producer/FIFO side.
interface fifo_rr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_w_en;
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic                          grant_valid;
    logic [ID_W-1:0]               grant_id;

    modport master (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_w_en, fifo_data_in, grant_valid, grant_id
    );

    modport slave (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_w_en, fifo_data_in, grant_valid, grant_id
    );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among NUM_REQ producers,
// holding each grant for up to MAX_BURST accepted beats.
module fifo_rr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_rr_arbiter_if.master  bus
);
    localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    logic                grant_valid;
    logic [ID_W-1:0]     grant_id;
    logic [ID_W-1:0]     rr_ptr;
    logic [CNT_W-1:0]    burst_cnt;

    logic [NUM_REQ-1:0]  rot;
    logic                any_valid;
    logic [ID_W-1:0]     off;
    logic [ID_W:0]       sum;
    logic [ID_W-1:0]     sel;
    logic [ID_W-1:0]     sel_next;

    logic                g_valid;
    logic                g_last;
    logic [DATA_WIDTH-1:0] g_data;
    logic [NUM_REQ-1:0]  ready;
    logic                accept;

    // Rotate valid so rr_ptr sits at bit 0; the lowest set bit is the next in line.
    always_comb begin
        rot       = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr);
        any_valid = |rot;
        off       = '0;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            if (rot[k-1]) off = ID_W'(k - 1);
        end
        sum      = {1'b0, rr_ptr} + {1'b0, off};
        sel      = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ)) : ID_W'(sum);
        sel_next = (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
    end

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = bus.req_data[DATA_WIDTH-1:0];
        ready   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                g_valid  = bus.req_valid[i];
                g_last   = bus.req_last[i];
                g_data   = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                ready[i] = (state == BUSY) && !bus.fifo_full;
            end
        end
        accept = (state == BUSY) && g_valid && !bus.fifo_full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            rr_ptr      <= '0;
            burst_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_valid) begin
                        state       <= BUSY;
                        grant_valid <= 1'b1;
                        grant_id    <= sel;
                        burst_cnt   <= '0;
                        rr_ptr      <= sel_next;
                    end
                end
                BUSY: begin
                    if (!g_valid) begin
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                    end else if (accept) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        if (g_last || (burst_cnt == CNT_W'(MAX_BURST - 1))) begin
                            state       <= IDLE;
                            grant_valid <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready    = ready;
    assign bus.fifo_w_en    = accept;
    assign bus.fifo_data_in = g_data;
    assign bus.grant_valid  = grant_valid;
    assign bus.grant_id     = grant_id;
endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ independent producers. Each producer presents a valid/ready beat stream with an optional end-of-burst marker. The arbiter grants one producer at a time, holds the grant for up to MAX_BURST accepted beats, and drives the FIFO's w_en/data_in while respecting its full flag. It sits between the producer blocks and the synchronous_fifo instance.

## Interface
- NUM_REQ, 4, number of requesters; 2..16
- DATA_WIDTH, 8, beat width; must match the FIFO DATA_WIDTH
- MAX_BURST, 4, maximum beats accepted per grant; 1..255
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  per-requester end-of-burst marker, qualified by valid
- req_data  in  NUM_REQ*DATA_WIDTH  flattened beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  per-requester beat accepted this cycle (one-hot or zero)
- fifo_full  in  1  full flag from the FIFO
- fifo_w_en  out  1  FIFO write enable
- fifo_data_in  out  DATA_WIDTH  FIFO write data
- grant_valid  out  1  a requester currently holds the grant
- grant_id  out  max(1,$clog2(NUM_REQ))  index of the granted requester

## Operation
- Two-state FSM: IDLE, BUSY. Registered state: grant_id, grant_valid, burst counter (width $clog2(MAX_BURST+1)), and round-robin priority pointer rr_ptr.
- A beat is accepted from requester i when req_valid[i] && req_ready[i].
- Requester contract: once valid is raised, it stays high with data stable until the beat is accepted.

IDLE:
- If any req_valid is high, select the first valid index searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
- On the next edge: grant_id <= selected index, grant_valid <= 1, burst counter <= 0, rr_ptr <= (selected+1) mod NUM_REQ, state <= BUSY.
- If no req_valid is high, remain in IDLE.
- req_ready = 0 and fifo_w_en = 0 throughout IDLE.

BUSY (g = grant_id):
- Combinational: req_ready[g] = !fifo_full; all other ready bits are 0.
- Combinational: fifo_w_en = req_valid[g] && !fifo_full.
- Combinational: fifo_data_in = req_data slice g at all times; it is a don't-care when fifo_w_en = 0.
- Each accepted beat increments the burst counter.
- Release to IDLE on the next edge, clearing grant_valid, when any of the following holds:
  - an accepted beat has req_last[g] = 1;
  - an accepted beat brings the counter to MAX_BURST;
  - req_valid[g] = 0.
- fifo_full high: no acceptance, counter held, grant held indefinitely. There is no timeout.
- Valid from non-granted requesters is ignored; they wait.

Boundary rules:
- Wrap-around: rr_ptr wraps from NUM_REQ-1 to 0.
- Fairness: a continuously valid requester is granted within NUM_REQ grant cycles.
- Simultaneous last and MAX_BURST on the same beat: a single release.
- Reset mid-burst: immediate return to IDLE. In-flight beats are not written; the FIFO is reset separately.

## Timing
- Reset values: state IDLE, grant_valid 0, grant_id 0, counter 0, rr_ptr 0 (requester 0 has first priority), req_ready all 0, fifo_w_en 0. fifo_data_in reflects requester 0's data.
- Arbitration latency: one cycle. Valid seen in IDLE at edge N gives grant_valid = 1 after edge N+1, and the first beat can be accepted in the cycle following edge N+1.
- Release costs one IDLE cycle, so there is exactly one dead cycle between consecutive grants.
- Peak throughput: MAX_BURST beats per MAX_BURST+1 cycles when producers stream.
- Write path is combinational from req_valid/fifo_full to fifo_w_en/req_ready. There is no registered data stage, so a write lands in the FIFO at the same edge on which the beat is accepted.
- fifo_full must be a registered or glitch-free FIFO output; it is sampled in the same cycle.

## Test plan
- Single requester, NUM_REQ=4, MAX_BURST=4: req 2 streams 0x10..0x15 with no last → FIFO receives 0x10..0x13, one IDLE cycle, then 0x14, 0x15; grant_id = 2 throughout.
- All four requesters continuously valid: grant order is 0,1,2,3,0,… with four beats each and fifo_w_en low exactly one cycle between bursts.
- req 1 asserts last on its 2nd beat while req 3 is valid: req 1 is released after 2 beats, then req 3 is granted after one IDLE cycle.
- fifo_full is forced high for 5 cycles mid-burst: req_ready and fifo_w_en stay 0, the counter is frozen, and the grant holds. After full deasserts, the remaining beats complete with no loss or duplication.
- rst_n is pulsed low asynchronously mid-burst: grant_valid, req_ready and fifo_w_en go 0 immediately, and after release the first grant goes to the lowest valid index.
- The granted requester drops valid between beats after 1 beat: released, and rr_ptr still advances past it.
